// File: rtl/rgbled_spi_loader.sv
// SPI (mode 0, MSB first) frame loader feeding the WS2812 chain driver's parallel data word.
// Optional shift-through echo on spi_miso is enabled by defining RGBLED_SPI_ECHO_EN.
`timescale 1ns/1ps
module rgbled_spi_loader #(
   parameter int NUM_LEDS     = 3,
   parameter int BITS_PER_LED = 24
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             spi_sck,
   input  logic                             spi_cs_n,
   input  logic                             spi_mosi,
   output logic                             spi_miso,
   output logic [NUM_LEDS*BITS_PER_LED-1:0] data,
   output logic                             data_rdy,
   output logic                             frame_err
);

   localparam int W  = NUM_LEDS * BITS_PER_LED;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RECV = 1'b1
   } state_t;

   logic          r_sck_meta, r_sck_sync, r_sck_prev;
   logic          r_cs_meta, r_cs_sync;
   logic          r_mosi_meta, r_mosi_sync;
   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   // Low W-1 bits of the shift register; the top bit only matters for the echo path.
   logic [W-2:0]  r_shift;
   logic [W-1:0]  r_data;
   logic          r_data_rdy, r_frame_err;
   logic          w_rise, w_enter, w_leave, w_accept, w_done, w_abort;

   assign w_rise = r_sck_sync & ~r_sck_prev;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sck_meta  <= 1'b0;
         r_sck_sync  <= 1'b0;
         r_sck_prev  <= 1'b0;
         r_cs_meta   <= 1'b1;
         r_cs_sync   <= 1'b1;
         r_mosi_meta <= 1'b0;
         r_mosi_sync <= 1'b0;
      end else begin
         r_sck_meta  <= spi_sck;
         r_sck_sync  <= r_sck_meta;
         r_sck_prev  <= r_sck_sync;
         r_cs_meta   <= spi_cs_n;
         r_cs_sync   <= r_cs_meta;
         r_mosi_meta <= spi_mosi;
         r_mosi_sync <= r_mosi_meta;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (!r_cs_sync) w_next = S_RECV; else w_next = S_IDLE;
         S_RECV:  if (r_cs_sync)  w_next = S_IDLE; else w_next = S_RECV;
         default: w_next = S_IDLE;
      endcase
   end

   // A cs release in the same cycle as an sck rise wins: the edge is dropped.
   always_comb begin
      w_enter  = 1'b0;
      w_leave  = 1'b0;
      w_accept = 1'b0;
      w_done   = 1'b0;
      w_abort  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_enter = ~r_cs_sync;
         end
         S_RECV: begin
            w_leave  = r_cs_sync;
            w_accept = ~r_cs_sync & w_rise;
            w_done   = w_accept & (r_cnt == CW'(W - 1));
            w_abort  = r_cs_sync & (r_cnt != {CW{1'b0}});
         end
         default: begin
            w_enter = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= {CW{1'b0}};
         r_shift     <= {(W-1){1'b0}};
         r_data      <= {W{1'b0}};
         r_data_rdy  <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_data_rdy  <= 1'b0;
         r_frame_err <= w_abort;
         if (w_enter || w_leave) begin
            r_cnt <= {CW{1'b0}};
         end else if (w_done) begin
            r_cnt      <= {CW{1'b0}};
            r_data     <= {r_shift, r_mosi_sync};
            r_data_rdy <= 1'b1;
         end else if (w_accept) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_accept) begin
            r_shift <= {r_shift[W-3:0], r_mosi_sync};
         end
      end
   end

`ifdef RGBLED_SPI_ECHO_EN
   logic r_shift_msb, r_miso;

   // Echo emits the bit shifted in W accepted edges earlier.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shift_msb <= 1'b0;
         r_miso      <= 1'b0;
      end else begin
         if (w_enter) begin
            r_miso <= 1'b0;
         end else if (w_accept) begin
            r_miso <= r_shift_msb;
         end
         if (w_accept) begin
            r_shift_msb <= r_shift[W-2];
         end
      end
   end

   assign spi_miso = r_miso;
`else
   assign spi_miso = 1'b0;
`endif

   assign data      = r_data;
   assign data_rdy  = r_data_rdy;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_rgbled_spi_loader.sv
// Self-checking bench for rgbled_spi_loader: directed and random SPI frames against a bit-queue model.
`timescale 1ns/1ps
module tb_rgbled_spi_loader;
   localparam int W = 72;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         spi_sck = 1'b0;
   logic         spi_cs_n = 1'b1;
   logic         spi_mosi = 1'b0;
   logic         spi_miso;
   logic [W-1:0] data;
   logic         data_rdy;
   logic         frame_err;

   rgbled_spi_loader #(.NUM_LEDS(3), .BITS_PER_LED(24)) dut (
      .clk       (clk),
      .reset     (reset),
      .spi_sck   (spi_sck),
      .spi_cs_n  (spi_cs_n),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .data      (data),
      .data_rdy  (data_rdy),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: bits of the current CS window, and every bit accepted since reset.
   logic         q[$];
   logic         hist[$];
   logic [W-1:0] exp_data = '0;
   int           exp_rdy = 0;
   int           exp_err = 0;

   // Output observers.
   int  rdy_cnt = 0;
   int  err_cnt = 0;
   int  consec = 0;
   int  lat_bad = 0;
   time last_rise = 0;
   time rdy_t[$];
   logic prev_rdy = 1'b0;

   always @(negedge clk) begin
      if (data_rdy) begin
         rdy_cnt++;
         rdy_t.push_back($time);
         if (($time - last_rise) < 25 || ($time - last_rise) > 45) lat_bad++;
      end
      if (data_rdy && prev_rdy) consec++;
      prev_rdy = data_rdy;
      if (frame_err) err_cnt++;
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
`ifdef RGBLED_SPI_ECHO_EN
      logic exp_miso;
`endif
      spi_mosi = b;
      #40;
      spi_sck = 1'b1;
      last_rise = $time;
`ifdef RGBLED_SPI_ECHO_EN
      exp_miso = (hist.size() >= W) ? hist[hist.size() - W] : 1'b0;
`endif
      hist.push_back(b);
      q.push_back(b);
      if (q.size() == W) begin
         for (int i = 0; i < W; i++) exp_data[W-1-i] = q[i];
         exp_rdy++;
         q.delete();
      end
      #40;
      spi_sck = 1'b0;
`ifdef RGBLED_SPI_ECHO_EN
      chk("miso_echo", {{(W-1){1'b0}}, spi_miso}, {{(W-1){1'b0}}, exp_miso});
`else
      chk("miso_zero", {{(W-1){1'b0}}, spi_miso}, '0);
`endif
   endtask

   task automatic send_frame(input logic [W-1:0] f);
      for (int i = W - 1; i >= 0; i--) send_bit(f[i]);
   endtask

   task automatic cs_low();
      spi_cs_n = 1'b0;
      q.delete();
      #60;
      chk("miso_enter", {{(W-1){1'b0}}, spi_miso}, '0);
   endtask

   task automatic cs_high();
      spi_cs_n = 1'b1;
      if (q.size() != 0) exp_err++;
      q.delete();
      #60;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_data"}, data, exp_data);
      chk({tag, "_rdy_count"}, W'(rdy_cnt), W'(exp_rdy));
      chk({tag, "_err_count"}, W'(err_cnt), W'(exp_err));
   endtask

   logic [W-1:0] f;
   logic [W-1:0] held;
   time          gap;

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #20;
      chk("reset_data", data, '0);
      chk("reset_rdy", {{(W-1){1'b0}}, data_rdy}, '0);
      chk("reset_err", {{(W-1){1'b0}}, frame_err}, '0);
      chk("reset_miso", {{(W-1){1'b0}}, spi_miso}, '0);

      // Single frame.
      cs_low();
      send_frame(72'hFF_0000_00FF_00_0000FF);
      cs_high();
      check_outputs("single");
      chk("single_const", data, 72'hFF000000FF000000FF);
      chk("single_one_pulse", W'(rdy_cnt), W'(1));

      // Streaming two frames in one CS window.
      cs_low();
      send_frame(72'h1);
      send_frame({9{8'hA5}});
      cs_high();
      check_outputs("stream");
      chk("stream_const", data, {9{8'hA5}});
      gap = (rdy_t.size() >= 2) ? rdy_t[rdy_t.size()-1] - rdy_t[rdy_t.size()-2] : 0;
      chk("stream_gap_ok", {{(W-1){1'b0}}, (gap >= 72 * 80)}, {{(W-1){1'b0}}, 1'b1});

      // Partial frame, then a full frame.
      held = data;
      cs_low();
      repeat (40) send_bit(1'($urandom_range(0, 1)));
      cs_high();
      check_outputs("partial");
      chk("partial_held", data, held);
      cs_low();
      f = {8'($urandom), $urandom, $urandom};
      send_frame(f);
      cs_high();
      check_outputs("after_partial");
      chk("after_partial_const", data, f);

      // Idle noise with CS high.
      held = data;
      spi_mosi = 1'b1;
      repeat (100) begin
         #20;
         spi_sck = ~spi_sck;
      end
      #60;
      check_outputs("idle");
      chk("idle_held", data, held);

      // Echo: frame A then frame B in one window (miso checked on every bit).
      cs_low();
      send_frame({8'($urandom), $urandom, $urandom});
      send_frame({8'($urandom), $urandom, $urandom});
      cs_high();
      check_outputs("echo");

      // Random sessions: whole frames plus an optional ragged tail.
      for (int s = 0; s < 6; s++) begin
         cs_low();
         for (int k = 0; k < $urandom_range(1, 2); k++) begin
            send_frame({8'($urandom), $urandom, $urandom});
         end
         for (int k = 0; k < $urandom_range(0, 1) * $urandom_range(1, 71); k++) begin
            send_bit(1'($urandom_range(0, 1)));
         end
         cs_high();
         check_outputs("random");
      end

      // Reset in the middle of a frame.
      cs_low();
      repeat (30) send_bit(1'($urandom_range(0, 1)));
      reset = 1'b1;
      #1;
      chk("rst_mid_data", data, '0);
      chk("rst_mid_rdy", {{(W-1){1'b0}}, data_rdy}, '0);
      chk("rst_mid_err", {{(W-1){1'b0}}, frame_err}, '0);
      chk("rst_mid_miso", {{(W-1){1'b0}}, spi_miso}, '0);
      q.delete();
      hist.delete();
      exp_data = '0;
      spi_cs_n = 1'b1;
      #29;
      reset = 1'b0;
      #40;
      check_outputs("post_reset");
      cs_low();
      f = {8'($urandom), $urandom, $urandom};
      send_frame(f);
      cs_high();
      check_outputs("post_reset_frame");
      chk("post_reset_const", data, f);

      chk("no_back_to_back_rdy", W'(consec), '0);
      chk("rdy_latency", W'(lat_bad), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/rgbled_spi_loader.md
Name: rgbled_spi_loader

Overview:
- Upstream feeder for the WS2812-style RGB LED chain driver.
- Receives LED colour frames over a write-only SPI slave link (mode 0, MSB first) and assembles them into the driver's parallel `data` word.
- Presents each complete frame with a one-cycle `data_rdy` strobe.
- Sits between the external host pins and the LED driver's `data`/`data_rdy` inputs.

Parameters:
- NUM_LEDS, 3, number of LEDs in the chain.
- BITS_PER_LED, 24, colour bits per LED (GRB, 8 bits each).
- W (localparam), NUM_LEDS*BITS_PER_LED, frame width in bits (72 by default).

Ports:
- clk  input  1  system clock; all logic in this domain.
- reset  input  1  asynchronous, active-high reset.
- spi_sck  input  1  SPI clock from host, asynchronous to clk.
- spi_cs_n  input  1  SPI chip select, active low, asynchronous.
- spi_mosi  input  1  SPI data from host, asynchronous.
- spi_miso  output  1  shift-through data for daisy-chaining (see Optional Feature).
- data  output  W  last complete frame; first received bit at data[W-1].
- data_rdy  output  1  one-cycle pulse when `data` is updated.
- frame_err  output  1  one-cycle pulse when a partial frame is discarded.

Behaviour:
- Reset state (async assert, sync release): data=0, data_rdy=0, frame_err=0, spi_miso=0, shift register=0, bit counter=0, all synchronizers=0 except cs synchronizer=1 (idle).
- Synchronization: sck, cs_n and mosi each pass through 2 FFs. An sck history register follows the synchronized sck. rise = sck_s & ~sck_prev.
- Host constraint: sck high and low phases each ≥ 2 clk periods. No data is lost at sck ≤ clk/4.
- States: IDLE (cs_s=1) and RECV (cs_s=0).
- IDLE→RECV on cs_s=0: bit counter cleared to 0. The shift register is not cleared.
- RECV, rise: shift <= {shift[W-2:0], mosi_s}; cnt <= cnt+1.
- RECV, rise with cnt==W-1 (W-th bit):
  - data <= {shift[W-2:0], mosi_s}
  - data_rdy <= 1 for exactly the next cycle
  - cnt <= 0
  - Streaming continues: a further W bits within the same CS produce another frame, which overwrites `data`.
- RECV→IDLE on cs_s=1:
  - If cnt!=0: partial frame discarded, frame_err pulses 1 cycle, data unchanged.
  - If cnt==0: no pulse.
  - cnt <= 0.
- sck edges while cs_s=1 are ignored. If cs_s rises in the same cycle as rise, the edge is ignored (cs takes precedence).
- Latency: raw sck rising edge to data_rdy high is 3–4 clk cycles.
- `data` holds its value between frames. data_rdy never asserts on two consecutive cycles.
- Reset mid-frame: immediate clear to the reset state. The partial frame is lost without a frame_err pulse.
- Counter width: $clog2(W+1). It never exceeds W-1 in steady state.

Optional Feature:
- Macro: RGBLED_SPI_ECHO_EN
- Defined: on each accepted rise, spi_miso <= shift[W-1] (the bit before the shift). The host stream is echoed delayed by exactly W bits, so a second loader can chain off spi_miso. spi_miso clears to 0 on IDLE→RECV.
- Not defined: spi_miso is tied constant 0 and no echo logic is synthesized.

Test Plan:
- Single frame: CS low, send 0xFF0000_00FF00_0000FF (72 bits) at clk/8, CS high -> data=0xFF000000FF000000FF, exactly one data_rdy pulse, frame_err never asserts.
- Streaming: 144 bits in one CS, first frame 0x0...01, second 0xA5 repeated -> two data_rdy pulses ≥ 72 sck periods apart, final data=0xA5A5…A5.
- Partial frame: 40 bits then CS high -> one frame_err pulse, data keeps its previous value. A following full 72-bit frame loads correctly with cnt restarted.
- Idle noise: 100 sck toggles with mosi=1 and CS high -> data, data_rdy and frame_err unchanged/0.
- Reset mid-frame: assert reset after 30 bits -> all outputs 0 immediately. After release, a full frame loads and no frame_err appears.
- Echo (RGBLED_SPI_ECHO_EN): send frame A then frame B in one CS -> spi_miso reproduces frame A bit-for-bit during frame B's 72 bits. Without the macro, spi_miso stays 0 throughout.
